// File: rtl/cube_frame_buffer_n_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : cube_pkg
//  Description : Shared constants, types and helpers for the tear-free
//                light-cube frame buffer.
//  Revision    : 1.0  initial release
// ============================================================================
package cube_pkg;

   // Default cube geometry; one bit per LED
   localparam int SIDE    = 8;
   localparam int FRAME_W = SIDE * SIDE * SIDE;

   // Width of the statistics counters
   localparam int CNT_W = 16;

   // Fallback state machine encoding
   typedef enum logic [0:0] {
      TO_NORMAL   = 1'b0,
      TO_FALLBACK = 1'b1
   } to_state_e;

   // Source-select width: never narrower than one bit
   function automatic int sel_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/cube_frame_buffer_n_src_timeout.sv
`default_nettype none
// ============================================================================
//  Module      : cube_src_timeout
//  Description : Counts display scans without a frame from the active source
//                and switches to the fallback animation after TIMEOUT_SCANS.
//                Leaves fallback at the first scan_done after the active
//                source delivers a frame again.
//  Revision    : 1.0  initial release
// ============================================================================
module cube_src_timeout
   import cube_pkg::*;
#(
   parameter  int TIMEOUT_SCANS = 64,
   localparam int CW            = (TIMEOUT_SCANS < 1) ? 1 : $clog2(TIMEOUT_SCANS + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic scan_done,
   input  logic sel_valid,
   input  logic switch_evt,
   input  logic fb_allow,
   output logic fallback_active
);

   localparam logic [CW-1:0] T_MAX = CW'(TIMEOUT_SCANS);

   to_state_e     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          seen_q, seen_d;
   logic          seen_now;
   logic [CW-1:0] cnt_inc;

   // Next-state logic: a valid in the scan_done cycle still counts for that scan
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      seen_now = seen_q | sel_valid;
      seen_d   = seen_now;
      cnt_inc  = (cnt_q == T_MAX) ? cnt_q : cnt_q + 1'b1;
      if (switch_evt) begin
         // New source gets a fresh timeout window
         state_d = TO_NORMAL;
         cnt_d   = '0;
         seen_d  = 1'b0;
      end else if (scan_done) begin
         seen_d = 1'b0;
         case (state_q)
            TO_NORMAL: begin
               if (seen_now) begin
                  cnt_d = '0;
               end else begin
                  cnt_d = cnt_inc;
                  if (fb_allow && (cnt_inc == T_MAX)) begin
                     state_d = TO_FALLBACK;
                  end
               end
            end
            TO_FALLBACK: begin
               if (seen_now) begin
                  state_d = TO_NORMAL;
                  cnt_d   = '0;
               end
            end
            default: begin
               state_d = TO_NORMAL;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // State and counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= TO_NORMAL;
         cnt_q   <= '0;
         seen_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         seen_q  <= seen_d;
      end
   end

   assign fallback_active = (state_q == TO_FALLBACK);

endmodule
`default_nettype wire

// File: rtl/cube_frame_buffer_n.sv
`default_nettype none
// ============================================================================
//  Module      : cube_frame_buffer_n
//  Description : Tear-free double-buffered frame store for the light cube.
//                Captures the effective source into a back buffer and swaps
//                it to the front buffer only at display scan boundaries.
//                Supports freeze, deferred source switching and a timeout
//                fallback to the default animation.
//                Optional macro FRAME_STATS_EN enables drop/swap counters.
//  Revision    : 1.0  initial release
// ============================================================================
module cube_frame_buffer_n #(
   parameter  int SIDE          = cube_pkg::SIDE,
   parameter  int NUM_SRC       = 2,
   parameter  int FALLBACK_SRC  = 0,
   parameter  int TIMEOUT_SCANS = 64,
   localparam int FRAME_W       = SIDE * SIDE * SIDE,
   localparam int SEL_W         = cube_pkg::sel_w(NUM_SRC)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_SRC*FRAME_W-1:0] src_frame_flat,
   input  logic [NUM_SRC-1:0]         src_valid,
   input  logic [SEL_W-1:0]           src_sel,
   input  logic                       scan_done,
   input  logic                       freeze,
   output logic [FRAME_W-1:0]         frame_cube_flat,
   output logic                       frame_swap,
   output logic [SEL_W-1:0]           active_src,
   output logic                       fallback_active,
   output logic                       pending,
   output logic [cube_pkg::CNT_W-1:0] drop_cnt,
   output logic [cube_pkg::CNT_W-1:0] swap_cnt
);

   import cube_pkg::*;

   localparam logic [SEL_W-1:0] FB_IDX = SEL_W'(FALLBACK_SRC);

   logic [FRAME_W-1:0] front_q, front_d;
   logic [FRAME_W-1:0] back_q, back_d;
   logic               pending_q, pending_d;
   logic               frame_swap_q, frame_swap_d;
   logic [SEL_W-1:0]   active_src_q, active_src_d;

   logic [SEL_W-1:0]   sel_san;
   logic [SEL_W-1:0]   eff_src;
   logic [FRAME_W-1:0] eff_frame;
   logic               cap;
   logic               sel_valid;
   logic               swap;
   logic               switch_evt;
   logic               fb_allow;
   logic               fallback;

   // Out-of-range requests map onto the fallback source
   always_comb begin
      sel_san    = (int'(src_sel) < NUM_SRC) ? src_sel : FB_IDX;
      eff_src    = fallback ? FB_IDX : active_src_q;
      switch_evt = scan_done && (sel_san != active_src_q);
      fb_allow   = (active_src_q != FB_IDX) && (TIMEOUT_SCANS != 0);
   end

   // Source muxes: captured frame follows the effective source, while the
   // timeout watches the selected source even during fallback
   always_comb begin
      eff_frame = '0;
      cap       = 1'b0;
      sel_valid = 1'b0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (eff_src == SEL_W'(k)) begin
            eff_frame = src_frame_flat[k*FRAME_W +: FRAME_W];
            cap       = src_valid[k];
         end
         if (active_src_q == SEL_W'(k)) begin
            sel_valid = src_valid[k];
         end
      end
   end

   // Buffer control: swap uses the back buffer value before this cycle's capture
   always_comb begin
      swap         = scan_done && pending_q && !freeze;
      front_d      = swap ? back_q : front_q;
      back_d       = cap ? eff_frame : back_q;
      pending_d    = cap ? 1'b1 : (swap ? 1'b0 : pending_q);
      frame_swap_d = swap;
      active_src_d = scan_done ? sel_san : active_src_q;
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         front_q      <= '0;
         back_q       <= '0;
         pending_q    <= 1'b0;
         frame_swap_q <= 1'b0;
         active_src_q <= '0;
      end else begin
         front_q      <= front_d;
         back_q       <= back_d;
         pending_q    <= pending_d;
         frame_swap_q <= frame_swap_d;
         active_src_q <= active_src_d;
      end
   end

   cube_src_timeout #(
      .TIMEOUT_SCANS (TIMEOUT_SCANS)
   ) u_timeout (
      .clk             (clk),
      .rst             (rst),
      .scan_done       (scan_done),
      .sel_valid       (sel_valid),
      .switch_evt      (switch_evt),
      .fb_allow        (fb_allow),
      .fallback_active (fallback)
   );

`ifdef FRAME_STATS_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
   logic [CNT_W-1:0] swap_cnt_q, swap_cnt_d;
   logic             drop;

   // Saturating statistics; a capture that coincides with a swap is not a drop
   always_comb begin
      drop       = cap && pending_q && !swap;
      drop_cnt_d = (drop && (drop_cnt_q != CNT_MAX)) ? drop_cnt_q + 1'b1 : drop_cnt_q;
      swap_cnt_d = (swap && (swap_cnt_q != CNT_MAX)) ? swap_cnt_q + 1'b1 : swap_cnt_q;
   end

   // Statistics registers
   always_ff @(posedge clk) begin
      if (rst) begin
         drop_cnt_q <= '0;
         swap_cnt_q <= '0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
         swap_cnt_q <= swap_cnt_d;
      end
   end

   assign drop_cnt = drop_cnt_q;
   assign swap_cnt = swap_cnt_q;
`else
   assign drop_cnt = '0;
   assign swap_cnt = '0;
`endif

   assign frame_cube_flat = front_q;
   assign frame_swap      = frame_swap_q;
   assign active_src      = active_src_q;
   assign fallback_active = fallback;
   assign pending         = pending_q;

endmodule
`default_nettype wire

// File: tb/tb_cube_frame_buffer_n.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cube_frame_buffer_n
//  Description : Directed self-checking bench for cube_frame_buffer_n
//                (SIDE=8, NUM_SRC=2, FALLBACK_SRC=0, TIMEOUT_SCANS=4).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cube_frame_buffer_n;

`ifdef FRAME_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [511:0]  f0, f1;
   logic [1023:0] src_frame_flat;
   logic [1:0]    src_valid;
   logic [0:0]    src_sel;
   logic          scan_done;
   logic          freeze;
   logic [511:0]  frame_cube_flat;
   logic          frame_swap;
   logic [0:0]    active_src;
   logic          fallback_active;
   logic          pending;
   logic [15:0]   drop_cnt;
   logic [15:0]   swap_cnt;

   int n_vec = 0;
   int n_err = 0;

   logic [511:0] fr_a5, fr_11, fr_a, fr_b, fr_c, fr_d, fr_e, fr_5a, fr_77;

   assign src_frame_flat = {f1, f0};

   always #5 clk = ~clk;

   cube_frame_buffer_n #(
      .SIDE          (8),
      .NUM_SRC       (2),
      .FALLBACK_SRC  (0),
      .TIMEOUT_SCANS (4)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .src_frame_flat  (src_frame_flat),
      .src_valid       (src_valid),
      .src_sel         (src_sel),
      .scan_done       (scan_done),
      .freeze          (freeze),
      .frame_cube_flat (frame_cube_flat),
      .frame_swap      (frame_swap),
      .active_src      (active_src),
      .fallback_active (fallback_active),
      .pending         (pending),
      .drop_cnt        (drop_cnt),
      .swap_cnt        (swap_cnt)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic vpulse(input int k);
      src_valid    = '0;
      src_valid[k] = 1'b1;
      cyc();
      src_valid    = '0;
   endtask

   task automatic scan();
      scan_done = 1'b1;
      cyc();
      scan_done = 1'b0;
   endtask

   initial begin
      fr_a5 = {64{8'hA5}};
      fr_11 = {64{8'h11}};
      fr_a  = {64{8'h3C}};
      fr_b  = {64{8'hC3}};
      fr_c  = {64{8'h96}};
      fr_d  = {64{8'h69}};
      fr_e  = {64{8'hF0}};
      fr_5a = {64{8'h5A}};
      fr_77 = {64{8'h77}};

      rst = 1'b1; f0 = '0; f1 = '0; src_valid = '0; src_sel = 1'b1;
      scan_done = 1'b0; freeze = 1'b0;
      cyc(); cyc();

      // Reset state
      chk("rst_front", frame_cube_flat, '0);
      chk("rst_pending", pending, 0);
      chk("rst_swap", frame_swap, 0);
      chk("rst_active", active_src, 0);
      chk("rst_fallback", fallback_active, 0);
      chk("rst_drop", drop_cnt, 0);
      chk("rst_swapcnt", swap_cnt, 0);
      rst = 1'b0;

      // Deferred switch: src_sel=1 takes effect only at scan_done
      cyc(); cyc(); cyc();
      chk("defer_active_hold", active_src, 0);
      scan();
      chk("defer_active_new", active_src, 1);
      chk("defer_no_swap", frame_swap, 0);

      // Basic swap; source 0 pulses are ignored
      f0 = fr_11; f1 = fr_a5;
      vpulse(0);
      chk("basic_ignore_src0", pending, 0);
      vpulse(1);
      chk("basic_pending", pending, 1);
      repeat (10) cyc();
      chk("basic_front_before", frame_cube_flat, '0);
      scan();
      chk("basic_front", frame_cube_flat, fr_a5);
      chk("basic_swap_pulse", frame_swap, 1);
      chk("basic_pending_clr", pending, 0);
      cyc();
      chk("basic_swap_end", frame_swap, 0);

      // Overwrite: latest frame wins, one drop
      f1 = fr_a; vpulse(1);
      f1 = fr_b; vpulse(1);
      scan();
      chk("ovw_front", frame_cube_flat, fr_b);
      chk("ovw_drop", drop_cnt, STATS ? 16'd1 : 16'd0);
      chk("ovw_swapcnt", swap_cnt, STATS ? 16'd2 : 16'd0);

      // Simultaneous capture and swap
      f1 = fr_b; vpulse(1);
      f1 = fr_c; src_valid = 2'b10; scan_done = 1'b1;
      cyc();
      src_valid = '0; scan_done = 1'b0;
      chk("sim_front", frame_cube_flat, fr_b);
      chk("sim_pending", pending, 1);
      chk("sim_swap_pulse", frame_swap, 1);
      chk("sim_no_drop", drop_cnt, STATS ? 16'd1 : 16'd0);
      cyc();
      scan();
      chk("sim_front2", frame_cube_flat, fr_c);
      chk("sim_pending2", pending, 0);

      // Freeze suppresses swaps across three scans
      f1 = fr_d; vpulse(1);
      freeze = 1'b1;
      for (int i = 0; i < 3; i++) begin
         scan();
         chk("frz_front", frame_cube_flat, fr_c);
         chk("frz_no_swap", frame_swap, 0);
      end
      freeze = 1'b0;
      cyc();
      scan();
      chk("frz_release_front", frame_cube_flat, fr_d);
      chk("frz_release_swap", frame_swap, 1);
      chk("frz_no_fallback_3", fallback_active, 0);

      // Timeout: fresh frame then four empty scans
      f1 = fr_e; vpulse(1);
      scan();
      chk("to_front", frame_cube_flat, fr_e);
      for (int i = 0; i < 3; i++) begin
         scan();
      end
      chk("to_before_limit", fallback_active, 0);
      scan();
      chk("to_fallback_on", fallback_active, 1);
      chk("to_front_hold", frame_cube_flat, fr_e);
      f0 = fr_5a; vpulse(0);
      chk("to_cap_src0", pending, 1);
      scan();
      chk("to_front_src0", frame_cube_flat, fr_5a);
      chk("to_still_fb", fallback_active, 1);
      chk("to_swapcnt", swap_cnt, STATS ? 16'd7 : 16'd0);
      f1 = fr_77; vpulse(1);
      chk("to_src1_not_cap", pending, 0);
      chk("to_fb_until_scan", fallback_active, 1);
      scan();
      chk("to_fallback_off", fallback_active, 0);
      chk("to_front_keep", frame_cube_flat, fr_5a);
      chk("to_no_swap", frame_swap, 0);

      // Switch back to source 0 mid-scan, then reset with a pending frame
      src_sel = 1'b0;
      cyc(); cyc(); cyc();
      chk("sw_hold", active_src, 1);
      scan();
      chk("sw_new", active_src, 0);
      f0 = fr_a5; vpulse(0);
      chk("sw_pending", pending, 1);
      chk("sw_drop_before_rst", drop_cnt, STATS ? 16'd1 : 16'd0);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("mrst_front", frame_cube_flat, '0);
      chk("mrst_pending", pending, 0);
      chk("mrst_drop", drop_cnt, 0);
      chk("mrst_swapcnt", swap_cnt, 0);
      chk("mrst_active", active_src, 0);
      scan();
      chk("mrst_no_swap", frame_swap, 0);
      chk("mrst_front_after", frame_cube_flat, '0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
